// File: rtl/scan_sequencer.sv
// Slot sequencer for a 4-to-16 decoder: walks the set bits of a latched mask,
// holding each slot for dwell+1 cycles, as a single pass or continuously.
module scan_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        mask,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               enable,
  output logic               busy,
  output logic               done
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic               r_state;
  logic [3:0]         r_slot;
  logic               r_enable;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;

  logic [16:0]        w_keep;
  logic [16:0]        w_above;
  logic               w_has_above;
  logic [3:0]         w_next_slot;
  logic [3:0]         w_first_in;
  logic [3:0]         w_first_latched;
  logic               w_launch;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (v[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

  // 17-bit width so that slot 15 leaves no candidate bits above it.
  always_comb begin
    w_keep          = ~((17'd2 << r_slot) - 17'd1);
    w_above         = {1'b0, r_mask} & w_keep;
    w_has_above     = |w_above;
    w_next_slot     = lowest_set(w_above[15:0]);
    w_first_in      = lowest_set(mask);
    w_first_latched = lowest_set(r_mask);
    w_launch        = start && !stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_slot   <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mask   <= '0;
      r_dwell  <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            if (mask != 16'h0000) begin
              r_mask   <= mask;
              r_dwell  <= dwell;
              r_cnt    <= dwell;
              r_slot   <= w_first_in;
              r_enable <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= ST_ACTIVE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          // stop outranks a dwell expiry in the same cycle
          if (stop) begin
            r_state  <= ST_IDLE;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
          end else if (r_cnt == '0) begin
            if (w_has_above) begin
              r_slot <= w_next_slot;
              r_cnt  <= r_dwell;
            end else if (mode) begin
              r_slot <= w_first_latched;
              r_cnt  <= r_dwell;
            end else begin
              r_state  <= ST_IDLE;
              r_enable <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_enable <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign a      = r_slot[3];
  assign b      = r_slot[2];
  assign c      = r_slot[1];
  assign d      = r_slot[0];
  assign enable = r_enable;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
